dense_0_mac: RTL and testbench
==============================

Name: dense_0_mac

Overview:
- Sequencer and multiply-accumulate engine for dense layer 0. It consumes the weight memory of that layer (8-bit words, registered read, 1-cycle latency, 507 words organised as 3 neurons x 169 inputs).
- It drives the weight memory address/enable and the flattened activation buffer read port in lockstep, and computes one zero-point-corrected dot product per output neuron.
- Each dot product is delivered through a valid/ready output to the output quantization stage.

Parameters:
- numInputs, 169, activations per neuron (13x13 flattened feature map)
- numOutputs, 3, output neurons; weight memory depth = numInputs*numOutputs
- addressWidthDense, 10, weight address width
- addressWidthAct, 8, activation address width
- dataWidthDense, 8, weight width, two's complement
- dataWidthAct, 8, activation width, unsigned
- accWidth, 32, accumulator/output width, signed
- offset_ent, 1, activation zero point, subtracted from each activation
- offset_fil, 0, weight zero point, subtracted from each weight

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to process one input vector
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the last neuron handshakes
- w_en  output  1  weight memory read enable
- w_addr  output  addressWidthDense  weight address
- w_rdata  input  dataWidthDense  weight data, valid 1 cycle after w_en
- act_en  output  1  activation buffer read enable
- act_addr  output  addressWidthAct  activation address
- act_rdata  input  dataWidthAct  activation data, valid 1 cycle after act_en
- out_valid  output  1  out_data/out_idx valid
- out_ready  input  1  consumer accepts the result
- out_idx  output  2  neuron index 0..numOutputs-1
- out_data  output  accWidth  signed dot product

Behaviour:
- One clock (clk); reset rst is synchronous, active-high. Reset at any time, including mid-operation, forces IDLE on the next edge.
- Reset values: all outputs 0; counters, accumulator and pipeline valids 0.
- FSM states: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - start=1 -> RUN; input index i=0, neuron j=0, weight pointer wp=0, acc=0, busy=1.
  - start while busy is ignored.
- RUN:
  - Each cycle w_en=act_en=1, w_addr=wp, act_addr=i; then i++ and wp++.
  - When i==numInputs-1 is issued -> DRAIN.
  - w_addr is a running pointer (no multiply): neuron j's weights occupy j*numInputs .. j*numInputs+numInputs-1.
- Pipeline:
  - s1: read data returns and is marked valid.
  - s1->s2: prod = ($signed({1'b0,act}) - offset_ent) * ($signed(w) - offset_fil), 9x9-bit signed operands giving an 18-bit product, registered.
  - s2: acc <= acc + sign-extended prod.
  - Last product lands in acc 2 cycles after the last issue.
- DRAIN: lasts exactly 2 cycles with w_en=act_en=0, then -> OUT.
- OUT:
  - out_valid=1, out_idx=j, out_data=acc. All three stay stable until out_ready=1.
  - No reads are issued while waiting.
  - On handshake with j<numOutputs-1: j++, acc=0, i=0, -> RUN. wp continues from its current value.
  - On handshake with j==numOutputs-1: -> IDLE, busy=0, done=1 for exactly one cycle.
  - out_ready is sampled only in OUT; out_ready=1 outside OUT has no effect.
- Cycle budget:
  - Per neuron: numInputs issue cycles + 2 drain cycles + handshake wait.
  - Start-to-first out_valid: 1 + numInputs + 2 = 172 cycles.
- Width rules:
  - Worst-case |sum| = 169*254*128 = 5,494,528, which fits accWidth=32 with no saturation.
  - out_data is the raw accumulator; requantization happens downstream.
- Boundary conditions:
  - After the last neuron, wp = numInputs*numOutputs (507) and is never issued.
  - start coincident with rst: rst wins.
  - start coincident with done: the new start is accepted only from IDLE on the following cycle.

Test Plan:
- Weights all 2, activations all 3, default offsets -> three results with out_idx 0,1,2, each out_data=676; done pulses once; first out_valid 172 cycles after start.
- Weights all 8'hFF (-1), activations all 0 -> each out_data=169. Weights 8'h80, activations 255 -> each out_data=-5,494,528.
- Neuron-distinct weights (neuron j weight = j+1), activation[i]=i+1:
  - out_data = (j+1)*sum(i) for i=0..168, i.e. 0:14196, 1:28392, 2:42588.
  - w_addr covers 0..506 exactly once, in order.
- Backpressure: hold out_ready=0 for 10 cycles on neuron 1 -> out_data/out_idx stable, w_en=act_en=0 throughout; result correct once accepted.
- Assert rst at cycle 50 of RUN -> next cycle busy=0, out_valid=0, w_en=0. A fresh start then yields the correct 676 results.
- Pulse start again while busy -> ignored: exactly 3 results and one done.

Source files
------------

// File: rtl/dense_0_mac_if.sv
// dense_0_mac_if: control, memory read and result handshake signals of the dense layer 0 MAC.
interface dense_0_mac_if #(
  parameter int AW_W = 10,
  parameter int AW_A = 8,
  parameter int DW_W = 8,
  parameter int DW_A = 8,
  parameter int ACC_W = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic              w_en;
  logic [AW_W-1:0]   w_addr;
  logic [DW_W-1:0]   w_rdata;
  logic              act_en;
  logic [AW_A-1:0]   act_addr;
  logic [DW_A-1:0]   act_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_idx;
  logic [ACC_W-1:0]  out_data;
  modport master (
    input  start, w_rdata, act_rdata, out_ready,
    output busy, done, w_en, w_addr, act_en, act_addr, out_valid, out_idx, out_data
  );
  modport slave (
    output start, w_rdata, act_rdata, out_ready,
    input  busy, done, w_en, w_addr, act_en, act_addr, out_valid, out_idx, out_data
  );
endinterface

// File: rtl/dense_0_mac.sv
// dense_0_mac: sequences weight/activation reads and accumulates one zero-point-corrected dot product per neuron.
module dense_0_mac #(
  parameter int NUM_INPUTS  = 169,
  parameter int NUM_OUTPUTS = 3,
  parameter int AW_W        = 10,
  parameter int AW_A        = 8,
  parameter int DW_W        = 8,
  parameter int DW_A        = 8,
  parameter int ACC_W       = 32,
  parameter int OFFSET_ENT  = 1,
  parameter int OFFSET_FIL  = 0
) (
  input logic clk,
  input logic rst,
  dense_0_mac_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
  localparam logic [AW_A-1:0] LAST_I = AW_A'(NUM_INPUTS - 1);
  localparam logic [1:0] LAST_J = 2'(NUM_OUTPUTS - 1);
  localparam int PW = DW_A + DW_W + 2;
  state_t state_q, state_d;
  logic [AW_A-1:0] i_q, i_d;
  logic [1:0] j_q, j_d;
  logic [AW_W-1:0] wp_q, wp_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic v1_q, v2_q, cnt_q, cnt_d, done_q, done_d;
  logic signed [DW_A:0] a_s;
  logic signed [DW_W:0] w_s;
  always_comb begin
    a_s = $signed({1'b0, bus.act_rdata}) - (DW_A+1)'(OFFSET_ENT);
    w_s = $signed({bus.w_rdata[DW_W-1], bus.w_rdata}) - (DW_W+1)'(OFFSET_FIL);
    prod_d = a_s * w_s;
  end
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    wp_d = wp_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    acc_d = v2_q ? acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q} : acc_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        i_d = '0;
        j_d = '0;
        wp_d = '0;
        acc_d = '0;
      end
      RUN: begin
        i_d = i_q + 1'b1;
        wp_d = wp_q + 1'b1;
        cnt_d = 1'b0;
        state_d = (i_q == LAST_I) ? DRAIN : RUN;
      end
      DRAIN: begin
        cnt_d = ~cnt_q;
        state_d = cnt_q ? OUT : DRAIN;
      end
      OUT: if (bus.out_ready) begin
        acc_d = '0;
        i_d = '0;
        done_d = (j_q == LAST_J);
        state_d = (j_q == LAST_J) ? IDLE : RUN;
        j_d = (j_q == LAST_J) ? j_q : j_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      wp_q <= '0;
      acc_q <= '0;
      prod_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      cnt_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      wp_q <= wp_d;
      acc_q <= acc_d;
      prod_q <= v1_q ? prod_d : prod_q;
      v1_q <= (state_q == RUN);
      v2_q <= v1_q;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
  // Read enables follow the state; the registered memory answers one cycle later into s1.
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.w_en = (state_q == RUN);
  assign bus.act_en = (state_q == RUN);
  assign bus.w_addr = wp_q;
  assign bus.act_addr = i_q;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_idx = j_q;
  assign bus.out_data = acc_q;
endmodule

// File: tb/tb_dense_0_mac.sv
// tb_dense_0_mac: scoreboard bench for dense_0_mac with behavioural weight/activation memories.
module tb_dense_0_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int results = 0;
  int dones = 0;
  logic [7:0] wmem [0:511];
  logic [7:0] amem [0:255];
  logic [33:0] exp_q [$];
  int addr_log [$];
  bit log_en = 1'b0;
  dense_0_mac_if bus ();
  dense_0_mac dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.w_en) bus.w_rdata <= wmem[bus.w_addr];
    if (bus.act_en) bus.act_rdata <= amem[bus.act_addr];
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done) dones++;
    if (log_en && bus.w_en) addr_log.push_back(int'(bus.w_addr));
    if (bus.w_en !== bus.act_en) chk("lockstep", {63'd0, bus.w_en}, {63'd0, bus.act_en});
    if (bus.out_valid && bus.out_ready) begin
      results++;
      if (exp_q.size() == 0) chk("unexpected_result", {30'd0, bus.out_idx, bus.out_data}, 64'hdead);
      else chk("result", {30'd0, bus.out_idx, bus.out_data}, {30'd0, exp_q.pop_front()});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input int mode);
    for (int a = 0; a < 256; a++) amem[a] = (mode == 0) ? 8'd3 : (mode == 1) ? 8'd0 : (mode == 2) ? 8'd255 : 8'(a + 1);
    for (int w = 0; w < 512; w++) wmem[w] = (mode == 0) ? 8'd2 : (mode == 1) ? 8'hFF : (mode == 2) ? 8'h80 : 8'(w / 169 + 1);
  endtask
  task automatic push3(input int e0, input int e1, input int e2);
    exp_q.push_back({2'd0, 32'(e0)});
    exp_q.push_back({2'd1, 32'(e1)});
    exp_q.push_back({2'd2, 32'(e2)});
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", {63'd0, n < 3000}, 64'd1);
    repeat (3) tick();
  endtask
  initial begin
    int n, d0, r0;
    bit stable;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    bus.w_rdata = '0;
    bus.act_rdata = '0;
    fill(0);
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.w_en, bus.act_en, bus.out_valid, bus.out_idx, bus.out_data, bus.w_addr, bus.act_addr}, 64'd0);
    tick();
    // basic run with latency and done pulse
    d0 = dones;
    push3(676, 676, 676);
    pulse_start();
    n = 1;
    while (!bus.out_valid && n < 400) begin
      tick();
      n++;
    end
    chk("first_valid_latency", 64'(n), 64'd172);
    wait_idle();
    chk("done_pulses", 64'(dones - d0), 64'd1);
    fill(1);
    push3(169, 169, 169);
    pulse_start();
    wait_idle();
    fill(2);
    push3(-5494528, -5494528, -5494528);
    pulse_start();
    wait_idle();
    // distinct weights and address coverage
    fill(3);
    addr_log.delete();
    log_en = 1'b1;
    push3(14196, 28392, 42588);
    pulse_start();
    wait_idle();
    log_en = 1'b0;
    chk("addr_count", 64'(addr_log.size()), 64'd507);
    n = 0;
    foreach (addr_log[k]) if (addr_log[k] != k && n == 0) n = k + 1;
    chk("addr_order_first_bad", 64'(n), 64'd0);
    chk("final_w_addr", 64'(bus.w_addr), 64'd507);
    // backpressure on neuron 1
    push3(14196, 28392, 42588);
    pulse_start();
    n = 0;
    while (!(bus.out_valid && bus.out_idx == 2'd1) && n < 1000) begin
      tick();
      n++;
    end
    bus.out_ready = 1'b0;
    chk("bp_reach_neuron1", {63'd0, n < 1000}, 64'd1);
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!bus.out_valid || bus.out_idx != 2'd1 || bus.out_data != 32'd28392 || bus.w_en || bus.act_en) stable = 1'b0;
    end
    chk("bp_stable", {63'd0, stable}, 64'd1);
    bus.out_ready = 1'b1;
    wait_idle();
    // reset in the middle of RUN
    fill(0);
    pulse_start();
    repeat (49) tick();
    chk("run_before_reset", {62'd0, bus.busy, bus.w_en}, 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset", {61'd0, bus.busy, bus.out_valid, bus.w_en}, 64'd0);
    tick();
    push3(676, 676, 676);
    pulse_start();
    wait_idle();
    // start while busy is ignored
    d0 = dones;
    r0 = results;
    push3(676, 676, 676);
    pulse_start();
    repeat (20) tick();
    pulse_start();
    repeat (160) tick();
    pulse_start();
    wait_idle();
    chk("busy_start_results", 64'(results - r0), 64'd3);
    chk("busy_start_done", 64'(dones - d0), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
